simplez_seq: RTL and testbench
==============================

SIMPLEZ_SEQ -- requirements
Module: simplez_seq

Interface
REQ-001 Parameters: none; opcode width fixed at 3, state code width fixed at 3.
REQ-002 clk  input  1  system clock; all state updates on the falling edge.
REQ-003 rstn  input  1  reset, synchronous, active-low.
REQ-004 co  input  3  opcode field RI[11:9] (ST=0, LD=1, ADD=2, BR=3, BZ=4, CLR=5, DEC=6, HALT=7).
REQ-005 ac_zero  input  1  accumulator equals zero.
REQ-006 mem_rdy  input  1  memory completes the current read/write this cycle.
REQ-007 Outputs, each 1 bit: lec (memory read), esc (memory write), era (load RA from internal address bus), incp (CP+1), ccp (load CP from internal address bus), scp (CP drives internal address bus), eri (load RI from data bus), sri (RI.CD drives internal address bus), eac (load AC from ALU), sac (AC drives data bus), stop (halted).
REQ-008 alu_op  output  2  00 pass data bus, 01 AC+bus, 10 AC-1, 11 clear.
REQ-009 state  output  3  current state code, for debug.

Function
REQ-010 States and codes: F0=0 (address fetch), F1=1 (instruction read), DX=2 (decode/execute), OP=3 (operand access), HLT=4.
REQ-011 F0: scp=1, era=1; next F1 unconditionally.
REQ-012 F1: lec=1; eri=1 and incp=1 only in the cycle mem_rdy=1; next DX on mem_rdy=1, else remain F1.
REQ-013 incp and eri SHALL be asserted exactly once per instruction regardless of wait cycles.
REQ-014 DX, co=CLR: eac=1, alu_op=11; next F0.
REQ-015 DX, co=DEC: eac=1, alu_op=10; next F0; AC wrap 0->0xFFF is datapath behaviour, no sequencer action.
REQ-016 DX, co=BR: sri=1, ccp=1; next F0.
REQ-017 DX, co=BZ: sri=1, ccp=1 only when ac_zero=1; otherwise no microorders; next F0.
REQ-018 DX, co in {ST, LD, ADD}: sri=1, era=1; next OP.
REQ-019 DX, co=HALT: no microorders; next HLT.
REQ-020 OP, ST: esc=1, sac=1 held until mem_rdy=1; next F0 on mem_rdy.
REQ-021 OP, LD: lec=1; eac=1, alu_op=00 in the mem_rdy cycle; next F0 on mem_rdy.
REQ-022 OP, ADD: lec=1; eac=1, alu_op=01 in the mem_rdy cycle; next F0 on mem_rdy.
REQ-023 co is sampled in DX and OP from the live input; RI is stable in those states because eri is asserted only in F1.
REQ-024 HLT: stop=1, all other microorders 0; remains in HLT until reset.
REQ-025 Unused codes 5-7 SHALL transition to F0 with all microorders 0.
REQ-026 Microorders not listed for a state SHALL be 0; alu_op defaults to 00.
REQ-027 Latency with mem_rdy tied high: CLR/DEC/BR/BZ 3 cycles; ST/LD/ADD 4 cycles.
REQ-028 lec and esc SHALL never be asserted together.

Reset
REQ-029 rstn=0 at a falling edge forces state to F0 from any state, including F1/OP with a pending memory access and HLT.
REQ-030 While rstn=0, all microorder outputs and stop SHALL be 0 and alu_op SHALL be 00.

Configuration
REQ-031 Macro SIMPLEZ_WAIT_EN defined: mem_rdy is honoured as specified in REQ-012 and REQ-020 to REQ-022.
REQ-032 SIMPLEZ_WAIT_EN undefined: mem_rdy port remains present but is ignored and treated as constant 1; every memory state lasts exactly one cycle.

Verification
REQ-033 Reset, then co=CLR, mem_rdy=1 -> states 0,1,2,0; eri and incp high once in state 1; eac=1 with alu_op=11 in state 2.
REQ-034 co=LD, mem_rdy low for 2 cycles in OP -> lec held 3 cycles, eac high only in the third cycle, alu_op=00, then F0.
REQ-035 co=BZ with ac_zero=0 -> no ccp; repeat with ac_zero=1 -> sri=1 and ccp=1 in DX.
REQ-036 co=HALT -> state 4, stop=1 indefinitely; rstn=0 for one edge -> state 0, stop=0.
REQ-037 rstn asserted in OP during an ST wait -> esc/sac drop to 0 and state=0 after the edge.
REQ-038 Build without SIMPLEZ_WAIT_EN and mem_rdy=0 -> ADD completes in 4 cycles, with eac high in OP.

Source files
------------

// File: rtl/simplez_seq.sv
// Simplez control sequencer: five-state fetch/decode/execute FSM that updates on the falling clock edge.
// Define SIMPLEZ_WAIT_EN to honour mem_rdy; otherwise every memory state lasts one cycle.
module simplez_seq (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] co,
    input  logic       ac_zero,
    input  logic       mem_rdy,
    output logic       lec,
    output logic       esc,
    output logic       era,
    output logic       incp,
    output logic       ccp,
    output logic       scp,
    output logic       eri,
    output logic       sri,
    output logic       eac,
    output logic       sac,
    output logic       stop,
    output logic [1:0] alu_op,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        F0  = 3'd0,
        F1  = 3'd1,
        DX  = 3'd2,
        OP  = 3'd3,
        HLT = 3'd4
    } state_t;

    localparam logic [2:0] CO_ST   = 3'd0;
    localparam logic [2:0] CO_LD   = 3'd1;
    localparam logic [2:0] CO_ADD  = 3'd2;
    localparam logic [2:0] CO_BR   = 3'd3;
    localparam logic [2:0] CO_BZ   = 3'd4;
    localparam logic [2:0] CO_CLR  = 3'd5;
    localparam logic [2:0] CO_DEC  = 3'd6;
    localparam logic [2:0] CO_HALT = 3'd7;

    localparam logic [1:0] ALU_PASS  = 2'b00;
    localparam logic [1:0] ALU_ADD   = 2'b01;
    localparam logic [1:0] ALU_DEC   = 2'b10;
    localparam logic [1:0] ALU_CLEAR = 2'b11;

    state_t r_state;
    state_t w_next;
    logic   w_rdy;

`ifdef SIMPLEZ_WAIT_EN
    assign w_rdy = mem_rdy;
`else
    // Zero-wait memory: the handshake input is kept on the port but never consulted.
    logic w_unused_mem_rdy;
    assign w_unused_mem_rdy = mem_rdy;
    assign w_rdy            = 1'b1;
`endif

    always_ff @(negedge clk) begin
        if (!rstn) begin
            r_state <= F0;
        end else begin
            r_state <= w_next;
        end
    end

    assign state = r_state;

    always_comb begin
        w_next = r_state;
        lec    = 1'b0;
        esc    = 1'b0;
        era    = 1'b0;
        incp   = 1'b0;
        ccp    = 1'b0;
        scp    = 1'b0;
        eri    = 1'b0;
        sri    = 1'b0;
        eac    = 1'b0;
        sac    = 1'b0;
        stop   = 1'b0;
        alu_op = ALU_PASS;

        case (r_state)
            F0: begin
                scp    = 1'b1;
                era    = 1'b1;
                w_next = F1;
            end

            // RI load and CP increment share the completing cycle so they fire once per fetch.
            F1: begin
                lec = 1'b1;
                if (w_rdy) begin
                    eri    = 1'b1;
                    incp   = 1'b1;
                    w_next = DX;
                end
            end

            DX: begin
                case (co)
                    CO_CLR: begin
                        eac    = 1'b1;
                        alu_op = ALU_CLEAR;
                        w_next = F0;
                    end
                    CO_DEC: begin
                        eac    = 1'b1;
                        alu_op = ALU_DEC;
                        w_next = F0;
                    end
                    CO_BR: begin
                        sri    = 1'b1;
                        ccp    = 1'b1;
                        w_next = F0;
                    end
                    CO_BZ: begin
                        sri    = ac_zero;
                        ccp    = ac_zero;
                        w_next = F0;
                    end
                    CO_ST, CO_LD, CO_ADD: begin
                        sri    = 1'b1;
                        era    = 1'b1;
                        w_next = OP;
                    end
                    CO_HALT: begin
                        w_next = HLT;
                    end
                endcase
            end

            OP: begin
                case (co)
                    CO_ST: begin
                        esc = 1'b1;
                        sac = 1'b1;
                        if (w_rdy) begin
                            w_next = F0;
                        end
                    end
                    CO_LD: begin
                        lec = 1'b1;
                        if (w_rdy) begin
                            eac    = 1'b1;
                            alu_op = ALU_PASS;
                            w_next = F0;
                        end
                    end
                    CO_ADD: begin
                        lec = 1'b1;
                        if (w_rdy) begin
                            eac    = 1'b1;
                            alu_op = ALU_ADD;
                            w_next = F0;
                        end
                    end
                    // Unreachable while RI is stable; recover to fetch rather than stall.
                    default: begin
                        w_next = F0;
                    end
                endcase
            end

            HLT: begin
                stop = 1'b1;
            end

            default: begin
                w_next = F0;
            end
        endcase

        // Reset silences every control line immediately, not just after the next edge.
        if (!rstn) begin
            lec    = 1'b0;
            esc    = 1'b0;
            era    = 1'b0;
            incp   = 1'b0;
            ccp    = 1'b0;
            scp    = 1'b0;
            eri    = 1'b0;
            sri    = 1'b0;
            eac    = 1'b0;
            sac    = 1'b0;
            stop   = 1'b0;
            alu_op = ALU_PASS;
        end
    end

endmodule

// File: tb/tb_simplez_seq.sv
// Self-checking bench for simplez_seq: each instruction's expected cycle sequence is derived
// from the instruction-level rules, with randomized opcodes, ac_zero, co junk and wait states.
module tb_simplez_seq;

    logic       clk;
    logic       rstn;
    logic [2:0] co;
    logic       ac_zero;
    logic       mem_rdy;
    logic       lec, esc, era, incp, ccp, scp, eri, sri, eac, sac, stop;
    logic [1:0] alu_op;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    localparam logic [10:0] NONE = 11'h000;
    localparam logic [10:0] LEC  = 11'h400;
    localparam logic [10:0] ESC  = 11'h200;
    localparam logic [10:0] ERA  = 11'h100;
    localparam logic [10:0] INCP = 11'h080;
    localparam logic [10:0] CCP  = 11'h040;
    localparam logic [10:0] SCP  = 11'h020;
    localparam logic [10:0] ERI  = 11'h010;
    localparam logic [10:0] SRI  = 11'h008;
    localparam logic [10:0] EAC  = 11'h004;
    localparam logic [10:0] SAC  = 11'h002;
    localparam logic [10:0] STOP = 11'h001;

    simplez_seq dut (
        .clk     (clk),
        .rstn    (rstn),
        .co      (co),
        .ac_zero (ac_zero),
        .mem_rdy (mem_rdy),
        .lec     (lec),
        .esc     (esc),
        .era     (era),
        .incp    (incp),
        .ccp     (ccp),
        .scp     (scp),
        .eri     (eri),
        .sri     (sri),
        .eac     (eac),
        .sac     (sac),
        .stop    (stop),
        .alu_op  (alu_op),
        .state   (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic eff_rdy(input logic r);
`ifdef SIMPLEZ_WAIT_EN
        return r;
`else
        return 1'b1;
`endif
    endfunction

    // Check one cycle at the rising edge (state changes on the falling edge), then advance.
    task automatic step_chk(input logic [2:0] exp_state, input logic [10:0] exp_mo,
                            input logic [1:0] exp_alu, input string tag);
        logic [10:0] mo;
        @(posedge clk);
        mo = {lec, esc, era, incp, ccp, scp, eri, sri, eac, sac, stop};
        checks++;
        assert ({state, mo, alu_op} === {exp_state, exp_mo, exp_alu}) else begin
            errors++;
            $error("FAIL %s: state/mo/alu got %0d/%03h/%0d want %0d/%03h/%0d",
                   tag, state, mo, alu_op, exp_state, exp_mo, exp_alu);
        end
        checks++;
        assert (!(lec === 1'b1 && esc === 1'b1)) else begin
            errors++;
            $error("FAIL %s_lec_esc: lec=%b esc=%b want not both 1", tag, lec, esc);
        end
        @(negedge clk);
        #1;
    endtask

    // Wait-length policy: w<0 picks a random length (max 3), otherwise exactly w waits.
    function automatic logic pick_rdy(input int w, input int n);
        if (w < 0) return (n >= 3) || ($urandom_range(0, 2) == 0);
        return n >= w;
    endfunction

    // Drive one instruction from F0 through DX (and OP), checking every cycle.
    task automatic run_instr(input logic [2:0] op, input logic az, input int f1w, input int opw);
        logic r;
        logic e;
        int   n;
        logic [10:0] mo;
        ac_zero = az;
        co      = 3'($urandom);
        mem_rdy = 1'($urandom);
        step_chk(3'd0, SCP | ERA, 2'b00, "F0");
        n = 0;
        do begin
            co      = 3'($urandom);
            r       = pick_rdy(f1w, n);
            mem_rdy = r;
            e       = eff_rdy(r);
            step_chk(3'd1, LEC | (e ? (ERI | INCP) : NONE), 2'b00, "F1");
            n++;
        end while (!e);
        co      = op;
        mem_rdy = 1'($urandom);
        case (op)
            3'd5: step_chk(3'd2, EAC, 2'b11, "DX_CLR");
            3'd6: step_chk(3'd2, EAC, 2'b10, "DX_DEC");
            3'd3: step_chk(3'd2, SRI | CCP, 2'b00, "DX_BR");
            3'd4: step_chk(3'd2, az ? (SRI | CCP) : NONE, 2'b00, "DX_BZ");
            3'd7: step_chk(3'd2, NONE, 2'b00, "DX_HALT");
            default: begin
                step_chk(3'd2, SRI | ERA, 2'b00, "DX_MEM");
                n = 0;
                do begin
                    r       = pick_rdy(opw, n);
                    mem_rdy = r;
                    e       = eff_rdy(r);
                    if (op == 3'd0) begin
                        step_chk(3'd3, ESC | SAC, 2'b00, "OP_ST");
                    end else begin
                        mo = LEC | (e ? EAC : NONE);
                        step_chk(3'd3, mo, (e && op == 3'd2) ? 2'b01 : 2'b00,
                                 op == 3'd1 ? "OP_LD" : "OP_ADD");
                    end
                    n++;
                end while (!e);
            end
        endcase
    endtask

    initial begin
        rstn    = 1'b0;
        co      = 3'd0;
        ac_zero = 1'b0;
        mem_rdy = 1'b1;
        @(negedge clk);
        #1;
        // Reset holds every control line low whatever the inputs say.
        co = 3'd7;
        step_chk(3'd0, NONE, 2'b00, "reset_hold");
        rstn = 1'b1;

        // CLR with zero-wait memory: states 0,1,2 then back to 0.
        run_instr(3'd5, 1'b0, 0, 0);
        // LD with two OP wait cycles.
        run_instr(3'd1, 1'b0, 0, 2);
        // BZ not taken, then taken.
        run_instr(3'd4, 1'b0, 0, 0);
        run_instr(3'd4, 1'b1, 0, 0);
        // ADD with waits in fetch and operand phases.
        run_instr(3'd2, 1'b0, 1, 3);
        run_instr(3'd0, 1'b1, 2, 1);
        run_instr(3'd6, 1'b0, 0, 0);
        run_instr(3'd3, 1'b1, 1, 0);

        for (int i = 0; i < 60; i++) begin
            run_instr(3'($urandom_range(0, 6)), 1'($urandom), -1, -1);
        end

        // HALT parks in state 4 until reset.
        run_instr(3'd7, 1'b0, -1, -1);
        for (int i = 0; i < 5; i++) begin
            co      = 3'($urandom);
            mem_rdy = 1'($urandom);
            step_chk(3'd4, STOP, 2'b00, "HLT");
        end
        rstn = 1'b0;
        step_chk(3'd4, NONE, 2'b00, "HLT_reset");
        rstn = 1'b1;
        run_instr(3'd6, 1'b1, 0, 0);

        // Reset during a store's operand cycle drops the write immediately and returns to F0.
        ac_zero = 1'b0;
        co      = 3'd3;
        mem_rdy = 1'b1;
        step_chk(3'd0, SCP | ERA, 2'b00, "F0");
        step_chk(3'd1, LEC | ERI | INCP, 2'b00, "F1");
        co      = 3'd0;
        step_chk(3'd2, SRI | ERA, 2'b00, "DX_MEM");
        mem_rdy = 1'b0;
        rstn    = 1'b0;
        step_chk(3'd3, NONE, 2'b00, "OP_ST_reset");
        rstn    = 1'b1;
        run_instr(3'd5, 1'b0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
